clkmeas: RTL
============

Name: clkmeas

Overview:
- Receive-side companion to the clock splitter: measures an incoming slow, divided clock or enable signal in fast `clk` cycles.
- Reports the period and high time of each cycle, and flags a stalled input.
- Used on board-level inputs and for self-checking divided clocks before downstream logic trusts them.

Parameters:
- MAX, 'd50000000, timeout limit and counter saturation value in clk cycles; counter width W = $clog2(MAX+1).
- T, 'd50000000, expected period in clk cycles (used only with CLKMEAS_LOCK_EN).
- TOL, 'd0, allowed ±deviation from T in clk cycles (used only with CLKMEAS_LOCK_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sig  input  1  asynchronous signal to measure.
- period  output  W  clk cycles between the last two rising edges.
- high  output  W  clk cycles sig was high during that period.
- valid  output  1  one-cycle strobe: period/high updated.
- timeout  output  1  level: no rising edge for MAX cycles.
- lock  output  1  period stable near T (macro-dependent).

Behaviour:
- Reset (rst_n low, asynchronous): period=0, high=0, valid=0, timeout=0, lock=0, all counters 0, state IDLE, synchronizer flops 0.
- Input conditioning:
  - 2-flop synchronizer on sig, then one delay flop.
  - rise = s & !s_d; fall = !s & s_d.
  - A rise is detected 3 clk cycles after sig rises at a clk edge.
- Counter `cnt` (W bits): on rise, cnt <= 1; otherwise cnt <= cnt+1, saturating at MAX. cnt therefore equals the number of cycles since the last rise.
- On fall: hold <= cnt (high time of the current period).
- State IDLE:
  - Waiting for the first reference edge.
  - On rise: go to MEAS, clear timeout, no valid.
- State MEAS:
  - On rise: period <= cnt, high <= hold, valid <= 1 in the next cycle (registered, 1-cycle pulse); stay in MEAS.
  - If cnt == MAX and no rise this cycle: timeout <= 1, go to IDLE, no valid.
- timeout is sticky until the next rise. period/high keep their last values across a timeout.
- No fall between two rises (synchronizer cannot produce this, but defend): high reports the stale hold; it is not checked.
- Minimum measurable period is 2: period=2, high=1.
- Rise and cnt==MAX in the same cycle: the rise wins. It is a valid measurement with period=MAX, and there is no timeout.
- Reset mid-measurement: everything clears. The first rise after release is a reference edge only.

Optional Feature:
- Macro: CLKMEAS_LOCK_EN.
- With CLKMEAS_LOCK_EN defined:
  - A 3-bit counter of consecutive in-tolerance measurements (|period−T| ≤ TOL, evaluated on each valid).
  - lock rises in the same cycle as the LOCK_CNT-th consecutive in-tolerance valid.
  - Any out-of-tolerance valid clears the counter and lock in the same cycle as that valid.
  - Timeout clears the counter and lock in the same cycle timeout rises.
- Without the macro: lock is tied to 0 and no comparator or counter is built.

Decomposition:
- Package clkmeas_pkg holds:
  - state enum {IDLE, MEAS};
  - localparam LOCK_CNT = 4;
  - the width helper function for W.
- One natural sub-module: sync_edge, which contains the 2-flop synchronizer, the delay flop, and the rise/fall outputs. Reset is active-low asynchronous. It is reusable for other async inputs.

Test Plan:
- Lock parameters for the lock scenarios: MAX=64, T=8, TOL=0.
- Steady input: sig with period 8 clk, high 5 clk.
  - First rise: no valid.
  - Every rise thereafter: valid pulse 4 cycles after the sig edge, period=8, high=5.
- Stall: sig held low after a rise.
  - timeout=1 exactly 64 cycles after the rise detection, with no valid.
  - Next rise: timeout=0, no valid.
  - Following rise: valid with the correct period.
- Fastest input: sig toggles every clk cycle → period=2, high=1 on every valid.
- Reset mid-period: rst_n low for 1 cycle during high phase.
  - All outputs 0 immediately.
  - First subsequent rise gives no valid; the second gives a correct measurement.
- Lock (macro on): 4 periods of 8.
  - lock=1 with the 4th valid.
  - Then one period of 10: lock=0 in that valid cycle.
  - Then 4 more periods of 8 to relock.
- Saturation boundary: rise exactly MAX=64 cycles after the previous rise → valid, period=64, timeout stays 0.

Source files
------------

// File: rtl/clkmeas_pkg.sv
// clkmeas_pkg: shared types and constants for the clkmeas block.
//   state_e    - measurement FSM states (IDLE waits for a reference edge,
//                MEAS times rise-to-rise intervals)
//   LOCK_CNT   - consecutive in-tolerance measurements needed for lock
//   cnt_width  - counter width able to hold the saturation value max_v
package clkmeas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  localparam int LOCK_CNT = 4;

  function automatic int cnt_width(input longint max_v);
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/clkmeas_if.sv
// clkmeas_if: measurement bus between the signal source / consumer and clkmeas.
//   sig     - asynchronous signal being measured (source -> clkmeas)
//   period  - clk cycles between the last two rising edges
//   high    - clk cycles sig was high during that period
//   valid   - one-cycle strobe, period/high just updated
//   timeout - level, no rising edge seen for MAX cycles
//   lock    - period stable near the expected value
// modport master: the source/consumer side; modport slave: the clkmeas side.
interface clkmeas_if #(
  parameter int W = 26
);
  logic         sig;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         timeout;
  logic         lock;

  modport master (output sig, input period, high, valid, timeout, lock);
  modport slave  (input sig, output period, high, valid, timeout, lock);
endinterface

// File: rtl/clkmeas_sync_edge.sv
// sync_edge: brings an asynchronous level into the clk domain and reports its
// edges. Two synchronizer flops followed by one delay flop; edges are derived
// from the synchronized level and its delayed copy.
//   clk     - sampling clock
//   rst_n   - asynchronous active-low reset, clears all flops
//   i_async - asynchronous input level
//   o_rise  - one-cycle pulse on a synchronized 0->1 transition
//   o_fall  - one-cycle pulse on a synchronized 1->0 transition
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a true three-stage shift;
      // blocking ones would collapse the chain into a single flop.
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/clkmeas.sv
// clkmeas: measures the period and high time of a slow asynchronous signal in
// clk cycles and flags a stalled input.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - clkmeas_if.slave: sig in; period, high, valid, timeout, lock out
// Parameters: MAX (timeout / counter saturation), T and TOL (expected period
// and allowed deviation, lock detector only).
// Build option: define CLKMEAS_LOCK_EN to build the lock detector; otherwise
// lock is tied low and no comparator or counter exists.
module clkmeas
  import clkmeas_pkg::*;
#(
  parameter int MAX = 50000000,
  parameter int T   = 50000000,
  parameter int TOL = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  clkmeas_if.slave bus
);

  localparam int           W     = cnt_width(MAX);
  localparam logic [W-1:0] MAX_W = W'(MAX);
  localparam logic [W-1:0] ONE_W = W'(1);

  // A lock window reaching past MAX could never be observed.
  if (T + TOL > MAX) begin : g_bad_param
    $error("clkmeas: T + TOL exceeds MAX");
  end

  logic         w_rise;
  logic         w_fall;
  logic         w_meas;     // rise in MEAS: publish a measurement
  logic         w_to;       // MAX cycles without a rise in MEAS
  state_e       r_state;
  state_e       w_state_nxt;
  logic [W-1:0] r_cnt;      // cycles since the last rise, saturating
  logic [W-1:0] r_hold;     // high time captured at the last fall
  logic [W-1:0] r_period;
  logic [W-1:0] r_high;
  logic         r_valid;
  logic         r_timeout;

  sync_edge u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.sig),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal assigned here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_meas      = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      IDLE: if (w_rise) w_state_nxt = MEAS;
      MEAS: begin
        // A rise landing on the saturation cycle is still a measurement.
        if (w_rise) begin
          w_meas = 1'b1;
        end else if (r_cnt == MAX_W) begin
          w_to        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The counter restarts at 1 on a rise, so at the next rise it holds the
  // full rise-to-rise distance and at a fall it holds the high time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_hold <= '0;
    end else begin
      if (w_rise)              r_cnt <= ONE_W;
      else if (r_cnt != MAX_W) r_cnt <= r_cnt + ONE_W;
      if (w_fall) r_hold <= r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= w_meas;
      if (w_meas) begin
        r_period <= r_cnt;
        r_high   <= r_hold;
      end
      // Sticky until the next rise; period/high keep their last values.
      if (w_rise)    r_timeout <= 1'b0;
      else if (w_to) r_timeout <= 1'b1;
    end
  end

  assign bus.period  = r_period;
  assign bus.high    = r_high;
  assign bus.valid   = r_valid;
  assign bus.timeout = r_timeout;

`ifdef CLKMEAS_LOCK_EN
  localparam logic [31:0] LOCK_LO = (T > TOL) ? 32'(T - TOL) : 32'd0;
  localparam logic [31:0] LOCK_HI = 32'(T + TOL);

  logic [2:0]  r_lock_cnt;  // consecutive in-tolerance measurements
  logic        r_lock;
  logic [31:0] w_cnt32;
  logic        w_in_tol;

  // r_cnt is the period being published this cycle, so lock tracks valid
  // without an extra cycle of latency.
  assign w_cnt32  = 32'(r_cnt);
  assign w_in_tol = (w_cnt32 >= LOCK_LO) && (w_cnt32 <= LOCK_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end else if (w_meas) begin
      if (w_in_tol) begin
        if (r_lock_cnt < 3'(LOCK_CNT)) r_lock_cnt <= r_lock_cnt + 3'd1;
        r_lock <= (r_lock_cnt >= 3'(LOCK_CNT - 1));
      end else begin
        r_lock_cnt <= '0;
        r_lock     <= 1'b0;
      end
    end else if (w_to) begin
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end
  end

  assign bus.lock = r_lock;
`else
  assign bus.lock = 1'b0;
`endif

endmodule
